instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of MainControl/ALUControl. Holds the PC and issues one-outstanding
//  req/ack reads to instruction memory. Buffers returned words with their PC in a small FIFO.

---
 rtl/instr_fetch_unit_pkg.sv | 43 ++++
 rtl/instr_fetch_unit_if.sv | 40 ++++
 rtl/instr_fetch_unit_fetch_fifo.sv | 48 ++++
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: instruction field positions,
// PC increment, FSM state encodings and a few opcode/funct constants for decode.
package instr_fetch_unit_pkg;

  localparam int OP_HI    = 31;
  localparam int OP_LO    = 26;
  localparam int RS_HI    = 25;
  localparam int RS_LO    = 21;
  localparam int RT_HI    = 20;
  localparam int RT_LO    = 16;
  localparam int RD_HI    = 15;
  localparam int RD_LO    = 11;
  localparam int SHAMT_HI = 10;
  localparam int SHAMT_LO = 6;
  localparam int FUNCT_HI = 5;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 15;
  localparam int IMM_LO   = 0;

  localparam int INSTR_W  = 32;
  localparam int PC_INCR  = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  function automatic logic is_rtype(input logic [5:0] op);
    return op == OPCODE_RTYPE;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory req/ack, redirect input and the
// decoded head instruction under a valid/ready handshake to decode.
interface instr_fetch_unit_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;

  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_pc;

  logic                dec_valid;
  logic                dec_ready;
  logic [5:0]          opCode;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [4:0]          shamt;
  logic [5:0]          funct;
  logic [15:0]         imm16;
  logic [PC_WIDTH-1:0] pc_out;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  redirect, redirect_pc,
    output dec_valid, opCode, rs, rt, rd, shamt, funct, imm16, pc_out,
    input  dec_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output redirect, redirect_pc,
    input  dec_valid, opCode, rs, rt, rd, shamt, funct, imm16, pc_out,
    output dec_ready
  );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs between fetch and decode.
// Flush empties it and wins over push/pop on the same edge.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_data,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [WIDTH-1:0]       o_head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  // Storage is not reset; occupancy is tracked by the pointers and count alone.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC register, one-outstanding imem request FSM, instruction buffer
// and combinational split of the head word into decode fields.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                CLK,
  input  logic                Reset_L,
  input  logic [PC_WIDTH-1:0] start_pc,
  instr_fetch_unit_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW = PC_WIDTH + INSTR_W;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = ~PC_WIDTH'(3);

  logic [1:0]          r_state;
  logic [1:0]          w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_nxt;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] w_addr_nxt;
  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_redir_pc;

  logic                w_ack_hit;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_cnt_nxt;
  logic [EW-1:0]       w_head;
  logic [INSTR_W-1:0]  w_instr;
  logic [PC_WIDTH-1:0] w_head_pc;

  assign w_pc_inc   = r_pc + PC_WIDTH'(PC_INCR);
  assign w_redir_pc = bus.redirect_pc & ALIGN_MASK;

  // An ack only counts while a request is actually on the bus.
  assign w_ack_hit = bus.imem_ack && bus.imem_req;
  assign w_push    = (r_state == S_WAIT) && w_ack_hit && !bus.redirect;
  assign w_pop     = !w_empty && bus.dec_ready && !bus.redirect;
  assign w_cnt_nxt = w_count + CW'(w_push) - CW'(w_pop);

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (Reset_L),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect),
    .i_data  ({r_pc, bus.imem_rdata}),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    if (bus.redirect) begin
      w_pc_nxt = w_redir_pc;
      // A request still in flight must be completed and its data dropped.
      case (r_state)
        S_WAIT, S_DISCARD: w_state_nxt = w_ack_hit ? S_IDLE : S_DISCARD;
        default:           w_state_nxt = S_IDLE;
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_full) begin
            w_state_nxt = S_WAIT;
            w_addr_nxt  = r_pc;
          end
        end
        S_WAIT: begin
          if (w_ack_hit) begin
            w_pc_nxt = w_pc_inc;
            if (w_cnt_nxt < DEPTH_CNT) w_addr_nxt  = w_pc_inc;
            else                       w_state_nxt = S_IDLE;
          end
        end
        S_DISCARD: begin
          if (w_ack_hit) w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      r_state <= S_IDLE;
      r_pc    <= start_pc & ALIGN_MASK;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  assign bus.imem_req  = (r_state == S_WAIT) || (r_state == S_DISCARD);
  assign bus.imem_addr = r_addr;

  // Fields read as zero whenever the buffer is empty.
  assign w_instr   = w_empty ? '0 : w_head[INSTR_W-1:0];
  assign w_head_pc = w_empty ? '0 : w_head[EW-1:INSTR_W];

  assign bus.dec_valid = !w_empty;
  assign bus.opCode    = w_instr[OP_HI:OP_LO];
  assign bus.rs        = w_instr[RS_HI:RS_LO];
  assign bus.rt        = w_instr[RT_HI:RT_LO];
  assign bus.rd        = w_instr[RD_HI:RD_LO];
  assign bus.shamt     = w_instr[SHAMT_HI:SHAMT_LO];
  assign bus.funct     = w_instr[FUNCT_HI:FUNCT_LO];
  assign bus.imm16     = w_instr[IMM_HI:IMM_LO];
  assign bus.pc_out    = w_head_pc;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a configurable-latency instruction memory.
module tb_instr_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [31:0] start_pc;

  instr_fetch_unit_if #(.PC_WIDTH(32)) bus ();

  instr_fetch_unit #(
    .PC_WIDTH   (32),
    .FIFO_DEPTH (2)
  ) dut (
    .CLK      (CLK),
    .Reset_L  (Reset_L),
    .start_pc (start_pc),
    .bus      (bus)
  );

  always #5 CLK = ~CLK;

  // Memory responder: ack once a request has been pending for lat cycles.
  int lat  = 0;
  int wcnt = 0;
  always_comb begin
    bus.imem_ack   = bus.imem_req && (wcnt >= lat);
    bus.imem_rdata = (bus.imem_addr == 32'h0040_0008) ? 32'h012A_4020 : ~bus.imem_addr;
  end
  always @(posedge CLK) begin
    if (bus.imem_req && !bus.imem_ack) wcnt <= wcnt + 1;
    else                               wcnt <= 0;
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc, input int latency);
    Reset_L         = 1'b0;
    start_pc        = pc;
    lat             = latency;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    tick();
    tick();
    Reset_L = 1'b1;
  endtask

  initial begin
    bus.dec_ready = 1'b1;

    // Test 1: reset state, then 0-wait streaming from 0x0040_0000
    do_reset(32'h0040_0000, 0);
    chk("rst_req",    64'(bus.imem_req),  64'd0);
    chk("rst_addr",   64'(bus.imem_addr), 64'd0);
    chk("rst_valid",  64'(bus.dec_valid), 64'd0);
    chk("rst_pc_out", 64'(bus.pc_out),    64'd0);
    chk("rst_opcode", 64'(bus.opCode),    64'd0);
    tick();
    chk("t1_req",     64'(bus.imem_req),  64'd1);
    chk("t1_addr0",   64'(bus.imem_addr), 64'h0040_0000);
    chk("t1_valid0",  64'(bus.dec_valid), 64'd0);
    tick();
    chk("t1_addr1",   64'(bus.imem_addr), 64'h0040_0004);
    chk("t1_valid1",  64'(bus.dec_valid), 64'd1);
    chk("t1_pc0",     64'(bus.pc_out),    64'h0040_0000);
    chk("t1_op0",     64'(bus.opCode),    64'h3F);
    tick();
    chk("t1_addr2",   64'(bus.imem_addr), 64'h0040_0008);
    chk("t1_pc1",     64'(bus.pc_out),    64'h0040_0004);
    tick();

    // Test 2: field split of add $8,$9,$10
    chk("t2_addr3",   64'(bus.imem_addr), 64'h0040_000C);
    chk("t2_pc",      64'(bus.pc_out),    64'h0040_0008);
    chk("t2_opcode",  64'(bus.opCode),    64'd0);
    chk("t2_rs",      64'(bus.rs),        64'd9);
    chk("t2_rt",      64'(bus.rt),        64'd10);
    chk("t2_rd",      64'(bus.rd),        64'd8);
    chk("t2_shamt",   64'(bus.shamt),     64'd0);
    chk("t2_funct",   64'(bus.funct),     64'h20);
    chk("t2_imm16",   64'(bus.imm16),     64'h4020);

    // Test 3: stall decode, FIFO fills, fetch stops then resumes in order
    bus.dec_ready = 1'b0;
    tick();
    chk("t3_req_off",  64'(bus.imem_req),  64'd0);
    chk("t3_addr_frz", 64'(bus.imem_addr), 64'h0040_000C);
    chk("t3_pc_hold",  64'(bus.pc_out),    64'h0040_0008);
    tick();
    chk("t3_req_off2", 64'(bus.imem_req),  64'd0);
    chk("t3_addr_frz2",64'(bus.imem_addr), 64'h0040_000C);
    bus.dec_ready = 1'b1;
    tick();
    chk("t3_drain_pc", 64'(bus.pc_out),    64'h0040_000C);
    chk("t3_drain_req",64'(bus.imem_req),  64'd0);
    tick();
    chk("t3_resume_req",  64'(bus.imem_req),  64'd1);
    chk("t3_resume_addr", 64'(bus.imem_addr), 64'h0040_0010);
    chk("t3_empty",       64'(bus.dec_valid), 64'd0);
    tick();
    chk("t3_resume_pc",   64'(bus.pc_out),    64'h0040_0010);

    // Test 4: 3-cycle memory, redirect while request outstanding
    do_reset(32'h0000_2000, 3);
    tick();
    chk("t4_req",   64'(bus.imem_req),  64'd1);
    chk("t4_addr",  64'(bus.imem_addr), 64'h2000);
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    tick();
    bus.redirect = 1'b0;
    chk("t4_disc_req",   64'(bus.imem_req),  64'd1);
    chk("t4_disc_addr",  64'(bus.imem_addr), 64'h2000);
    chk("t4_disc_valid", 64'(bus.dec_valid), 64'd0);
    tick();
    chk("t4_disc_ack",   64'(bus.imem_ack),  64'd1);
    tick();
    chk("t4_idle_req",   64'(bus.imem_req),  64'd0);
    chk("t4_dropped",    64'(bus.dec_valid), 64'd0);
    tick();
    chk("t4_new_addr",   64'(bus.imem_addr), 64'h0100);
    for (int i = 0; i < 20 && !bus.dec_valid; i++) tick();
    chk("t4_valid_seen", 64'(bus.dec_valid), 64'd1);
    chk("t4_first_pc",   64'(bus.pc_out),    64'h0100);
    chk("t4_first_op",   64'(bus.opCode),    64'h3F);

    // Test 5a: redirect coincident with ack and with pop
    do_reset(32'h0000_3000, 0);
    tick();
    tick();
    chk("t5_pre_valid", 64'(bus.dec_valid), 64'd1);
    chk("t5_pre_ack",   64'(bus.imem_ack),  64'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0500;
    tick();
    bus.redirect = 1'b0;
    chk("t5_flush_valid", 64'(bus.dec_valid), 64'd0);
    chk("t5_flush_req",   64'(bus.imem_req),  64'd0);
    tick();
    chk("t5_new_addr",    64'(bus.imem_addr), 64'h0500);
    tick();
    chk("t5_new_pc",      64'(bus.pc_out),    64'h0500);

    // Test 5b: redirect with pop on a full FIFO
    bus.dec_ready = 1'b0;
    tick();
    chk("t5_full_req",   64'(bus.imem_req),  64'd0);
    chk("t5_full_pc",    64'(bus.pc_out),    64'h0500);
    bus.dec_ready   = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0600;
    tick();
    bus.redirect = 1'b0;
    chk("t5_full_flush", 64'(bus.dec_valid), 64'd0);
    tick();
    chk("t5_full_req2",  64'(bus.imem_req),  64'd1);
    chk("t5_full_addr",  64'(bus.imem_addr), 64'h0600);
    tick();
    chk("t5_full_newpc", 64'(bus.pc_out),    64'h0600);

    // Test 6: PC wrap and reset in the middle of a request
    do_reset(32'hFFFF_FFFF, 0);
    tick();
    chk("t6_addr_top",  64'(bus.imem_addr), 64'hFFFF_FFFC);
    tick();
    chk("t6_addr_wrap", 64'(bus.imem_addr), 64'h0000_0000);
    chk("t6_pc_top",    64'(bus.pc_out),    64'hFFFF_FFFC);
    chk("t6_req_mid",   64'(bus.imem_req),  64'd1);
    Reset_L = 1'b0;
    tick();
    chk("t6_rst_req",   64'(bus.imem_req),  64'd0);
    chk("t6_rst_valid", 64'(bus.dec_valid), 64'd0);
    Reset_L = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
